// File: rtl/sopc_ledg_fader.sv
// sopc_ledg_fader: PWM brightness fader between the green-LED PIO out_port and the LEDG pins.
// Each channel's level ramps 1 LSB per prescaler tick toward full-on/off, or snaps when fades are off.
module sopc_ledg_fader #(
    parameter int PWM_BITS = 8,
    parameter int RAMP_DIV = 196
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] pattern_in,
    input  logic       fade_en,
    output logic [7:0] ledg,
    output logic       busy
);

    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] PWM_LAST = MAX - 1'b1;
    localparam int                  PRESC_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(RAMP_DIV - 1);

    logic [7:0]          target;
    logic [PWM_BITS-1:0] level [8];
    logic [PWM_BITS-1:0] tl [8];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PRESC_W-1:0]  presc;
    logic                tick;
    logic [7:0]          mismatch;

    assign tick = (presc == PRESC_LAST);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            tl[i]       = target[i] ? MAX : '0;
            mismatch[i] = (level[i] != tl[i]);
        end
    end

    assign busy = |mismatch;

    // Pattern sample, free-running ramp prescaler and PWM period counter (0..MAX-1).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target  <= '0;
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            target  <= pattern_in;
            presc   <= tick ? '0 : presc + 1'b1;
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
        end
    end

    // Targets are only ever 0 or MAX, so stepping toward them saturates without wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                level[i] <= '0;
                ledg[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                ledg[i] <= (level[i] > pwm_cnt);
                if (!fade_en) begin
                    level[i] <= tl[i];
                end else if (tick) begin
                    if (level[i] < tl[i]) begin
                        level[i] <= level[i] + 1'b1;
                    end else if (level[i] > tl[i]) begin
                        level[i] <= level[i] - 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sopc_ledg_fader.sv
// tb_sopc_ledg_fader: directed bench with an arithmetic reference model compared every cycle.
// A second, slowly ramping instance holds levels long enough to measure exact PWM duty.
module tb_sopc_ledg_fader;

    localparam int PWM_BITS = 4;
    localparam int RAMP_DIV = 2;
    localparam int MAX      = 15;
    localparam int SLOW_DIV = 200;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_reset_n;
    logic [7:0] pattern_in;
    logic [7:0] s_pattern;
    logic       fade_en;
    logic       s_fade;
    logic [7:0] ledg;
    logic [7:0] s_ledg;
    logic       busy;
    logic       s_busy;

    int   checks = 0;
    int   errors = 0;
    logic cmp_en = 1'b0;

    int         m_level [8];
    logic [7:0] m_target;
    logic [7:0] m_ledg;
    int         m_presc;
    int         m_pwm;

    always #5 clk = ~clk;

    sopc_ledg_fader #(.PWM_BITS(PWM_BITS), .RAMP_DIV(RAMP_DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pattern_in (pattern_in),
        .fade_en    (fade_en),
        .ledg       (ledg),
        .busy       (busy)
    );

    sopc_ledg_fader #(.PWM_BITS(PWM_BITS), .RAMP_DIV(SLOW_DIV)) dut_slow (
        .clk        (clk),
        .reset_n    (s_reset_n),
        .pattern_in (s_pattern),
        .fade_en    (s_fade),
        .ledg       (s_ledg),
        .busy       (s_busy)
    );

    function automatic int model_tl(input logic b);
        return b ? MAX : 0;
    endfunction

    function automatic logic model_busy();
        for (int i = 0; i < 8; i++) begin
            if (m_level[i] != model_tl(m_target[i])) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Reference model: levels as plain integers, stepping by the sign of (target - level) on ticks.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) m_level[i] <= 0;
            m_target <= 8'h00;
            m_ledg   <= 8'h00;
            m_presc  <= 0;
            m_pwm    <= 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                m_ledg[i] <= (m_level[i] > m_pwm);
                if (!fade_en)
                    m_level[i] <= model_tl(m_target[i]);
                else if (m_presc == RAMP_DIV - 1)
                    m_level[i] <= m_level[i] + int'(model_tl(m_target[i]) > m_level[i])
                                             - int'(model_tl(m_target[i]) < m_level[i]);
            end
            m_target <= pattern_in;
            m_presc  <= (m_presc + 1) % RAMP_DIV;
            m_pwm    <= (m_pwm + 1) % MAX;
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [7:0] p, input logic f);
        pattern_in = p;
        fade_en    = f;
    endtask

    task automatic count_busy(input int budget, output int n);
        n = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (busy) n++;
            else break;
        end
    endtask

    task automatic wait_level(input int value, input int budget, input string name);
        int found;
        found = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (m_level[0] == value) begin
                found = 1;
                break;
            end
        end
        check_output(name, found, 1);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("ledg_cycle", int'(ledg), int'(m_ledg));
            check_output("busy_cycle", int'(busy), int'(model_busy()));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        int found;
        int d0, d4, d5;

        reset_n   = 1'b1;
        s_reset_n = 1'b1;
        s_pattern = 8'h01;
        s_fade    = 1'b1;
        apply_stimulus(8'hFF, 1'b0);
        #1;
        reset_n   = 1'b0;
        s_reset_n = 1'b0;
        #1;
        cmp_en = 1'b1;

        // Reset held with all pattern bits set, then release with fades bypassed.
        @(negedge clk);
        check_output("reset_ledg", int'(ledg), 0);
        check_output("reset_busy", int'(busy), 0);
        step();
        step();
        reset_n = 1'b1;
        step();
        check_output("rel1_busy", int'(busy), 1);
        check_output("rel1_ledg", int'(ledg), 0);
        step();
        check_output("rel2_busy", int'(busy), 0);
        check_output("rel2_ledg", int'(ledg), 0);
        step();
        check_output("rel3_ledg", int'(ledg), 8'hFF);
        n = 0;
        repeat (20) begin
            step();
            if (ledg == 8'hFF) n++;
        end
        check_output("steady_ff", n, 20);

        // Fade up, started so that the first tick still sees the old target.
        apply_stimulus(8'h00, 1'b0);
        repeat (3) step();
        found = 0;
        for (int k = 0; k < 4; k++) begin
            if (m_presc == RAMP_DIV - 1) begin
                found = 1;
                break;
            end
            step();
        end
        check_output("align_tick", found, 1);
        apply_stimulus(8'h01, 1'b1);
        count_busy(40, n);
        check_output("fade_up_busy_cycles", n, 30);
        n = 0;
        repeat (15) begin
            step();
            if (ledg[0]) n++;
        end
        check_output("full_on_duty", n, 15);

        // Duty on the slow instance: level k for 200 cycles gives k highs per 15-cycle window.
        s_reset_n = 1'b1;
        d0 = 0;
        d4 = 0;
        d5 = 0;
        for (int k = 1; k <= 1024; k++) begin
            step();
            if (k >= 50 && k <= 64 && s_ledg[0]) d0++;
            if (k >= 810 && k <= 824 && s_ledg[0]) d4++;
            if (k >= 1010 && k <= 1024 && s_ledg[0]) d5++;
            if (k == 1010) check_output("slow_busy", int'(s_busy), 1);
        end
        check_output("duty_0", d0, 0);
        check_output("duty_4", d4, 4);
        check_output("duty_5", d5, 5);

        // Reversal at level 8.
        apply_stimulus(8'h00, 1'b0);
        repeat (3) step();
        apply_stimulus(8'h01, 1'b1);
        wait_level(8, 40, "reach_level_8");
        apply_stimulus(8'h00, 1'b1);
        count_busy(40, n);
        check_output("reversal_busy_cycles", n, 15);
        step();
        check_output("reversal_ledg_off", int'(ledg[0]), 0);

        // Bypass while rising at level 6.
        apply_stimulus(8'h00, 1'b0);
        repeat (3) step();
        apply_stimulus(8'h01, 1'b1);
        wait_level(6, 40, "reach_level_6");
        apply_stimulus(8'h01, 1'b0);
        step();
        check_output("bypass_busy", int'(busy), 0);
        n = 0;
        repeat (15) begin
            step();
            if (ledg[0]) n++;
        end
        check_output("bypass_duty", n, 15);

        // Asynchronous reset between edges at level 9, then ramp restarts from 0.
        apply_stimulus(8'h00, 1'b0);
        repeat (3) step();
        apply_stimulus(8'h01, 1'b1);
        wait_level(9, 40, "reach_level_9");
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async_ledg", int'(ledg), 0);
        check_output("async_busy", int'(busy), 0);
        step();
        step();
        reset_n = 1'b1;
        count_busy(40, n);
        check_output("restart_busy_cycles", n, 29);

        step();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
